// File: rtl/comparador_sar.sv
// Successive-approximation controller: drives comparator A, recovers B MSB-first; done WIDTH+1 cycles after start worst case.
// Optional CMP_ONEHOT_CHECK_EN aborts on non-one-hot flags and reports it on erro; start is ignored unless idle.
module comparador_sar #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             AmaiorB,
    input  logic             AmenorB,
    input  logic             AigualB,
    output logic [WIDTH-1:0] trial_a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             erro
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSCA, FIM} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_trial, w_trial_nx;
    logic [WIDTH-1:0] r_result, w_result_nx;
    logic [IW-1:0]    r_idx, w_idx_nx;
    logic             r_busy, w_busy_nx;
    logic             r_done, w_done_nx;
    logic [WIDTH-1:0] w_bit, w_bit_lo;

    // w_bit_lo is 1<<(idx-1); only used when idx>0
    assign w_bit    = ONE << r_idx;
    assign w_bit_lo = w_bit >> 1;

`ifdef CMP_ONEHOT_CHECK_EN
    logic r_erro, w_erro_nx;
    logic w_flags_ok;
    assign w_flags_ok = ({AmaiorB, AmenorB, AigualB} == 3'b100) ||
                        ({AmaiorB, AmenorB, AigualB} == 3'b010) ||
                        ({AmaiorB, AmenorB, AigualB} == 3'b001);
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_trial_nx  = r_trial;
        w_result_nx = r_result;
        w_idx_nx    = r_idx;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
        w_erro_nx   = r_erro;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = BUSCA;
                    w_trial_nx = MSB;
                    w_idx_nx   = IW'(WIDTH - 1);
                    w_busy_nx  = 1'b1;
`ifdef CMP_ONEHOT_CHECK_EN
                    w_erro_nx  = 1'b0;
`endif
                end
            end
            BUSCA: begin
`ifdef CMP_ONEHOT_CHECK_EN
                if (!w_flags_ok) begin
                    w_erro_nx   = 1'b1;
                    w_result_nx = r_trial;
                    w_state_nx  = FIM;
                    w_busy_nx   = 1'b0;
                    w_done_nx   = 1'b1;
                end else
`endif
                begin
                    if (AigualB) begin
                        w_result_nx = r_trial;
                        w_state_nx  = FIM;
                    end else if (AmaiorB) begin
                        if (r_idx != '0) begin
                            w_trial_nx = (r_trial & ~w_bit) | w_bit_lo;
                            w_idx_nx   = r_idx - IW'(1);
                        end else begin
                            w_result_nx = r_trial & ~ONE;
                            w_state_nx  = FIM;
                        end
                    end else begin
                        // menor, and all-zero flags when unchecked
                        if (r_idx != '0) begin
                            w_trial_nx = r_trial | w_bit_lo;
                            w_idx_nx   = r_idx - IW'(1);
                        end else begin
                            w_result_nx = r_trial;
                            w_state_nx  = FIM;
                        end
                    end
                    if (w_state_nx == FIM) begin
                        w_busy_nx = 1'b0;
                        w_done_nx = 1'b1;
                    end
                end
            end
            FIM: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_trial  <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_trial  <= w_trial_nx;
            r_result <= w_result_nx;
            r_idx    <= w_idx_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= w_erro_nx;
        end
    end
    assign erro = r_erro;
`else
    assign erro = 1'b0;
`endif

    assign trial_a = r_trial;
    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;

endmodule

// File: tb/tb_comparador_sar.sv
// Bench for comparador_sar: directed and random searches against a binary-search reference model.
module tb_comparador_sar;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         AmaiorB, AmenorB, AigualB;
    logic [W-1:0] trial_a, result;
    logic         busy, done, erro;

    logic [W-1:0] b_val = '0;
    bit           zero_flags = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // behavioural comparator on the B side
    assign AmaiorB = !zero_flags && (trial_a > b_val);
    assign AmenorB = !zero_flags && (trial_a < b_val);
    assign AigualB = !zero_flags && (trial_a == b_val);

    comparador_sar #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .AmaiorB (AmaiorB),
        .AmenorB (AmenorB),
        .AigualB (AigualB),
        .trial_a (trial_a),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .erro    (erro)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // k-th trial of a binary search for b: b's top k-1 bits, then a 1, then zeros
    function automatic int model_trial(input int b, input int k);
        int s;
        s = W - k;
        return ((b >> (s + 1)) << (s + 1)) | (1 << s);
    endfunction

    // cycles from start to done: equal at step k gives k+1, never equal gives W+1
    function automatic int model_lat(input int b);
        for (int k = 1; k <= W; k++)
            if (model_trial(b, k) == b) return k + 1;
        return W + 1;
    endfunction

    task automatic search(input int b, input bit pulse_mid, input bit zf);
        int cyc, exp_res, exp_lat, exp_err, tb_b;
        tb_b = zf ? (1 << W) - 1 : b;
`ifdef CMP_ONEHOT_CHECK_EN
        exp_res = zf ? (1 << (W - 1)) : b;
        exp_lat = zf ? 2 : model_lat(b);
        exp_err = zf ? 1 : 0;
`else
        exp_res = tb_b;
        exp_lat = model_lat(tb_b);
        exp_err = 0;
`endif
        @(negedge clk);
        b_val = W'(b);
        zero_flags = zf;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc <= W) chk("trial_a", 32'(trial_a), 32'(model_trial(tb_b, cyc)));
            chk("busy_in_search", 32'(busy), 1);
            start = (pulse_mid && cyc == 2);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("result", 32'(result), 32'(exp_res));
        chk("erro", 32'(erro), 32'(exp_err));
        chk("busy_at_done", 32'(busy), 0);
        @(posedge clk); #1;
        chk("done_pulse_width", 32'(done), 0);
        @(posedge clk); #1;
        chk("no_requeue_busy", 32'(busy), 0);
        chk("result_held", 32'(result), 32'(exp_res));
        zero_flags = 1'b0;
    endtask

    initial begin
        int cyc;
        #12;
        chk("rst_trial", 32'(trial_a), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_erro", 32'(erro), 0);
        @(negedge clk);
        rst_n = 1'b1;

        search(9, 1'b0, 1'b0);
        search(8, 1'b0, 1'b0);
        search(0, 1'b0, 1'b0);
        search(15, 1'b0, 1'b0);
        search(5, 1'b1, 1'b0);
        search(3, 1'b0, 1'b0);

        // reset in the second search cycle aborts everything
        @(negedge clk);
        b_val = 4'd11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_trial", 32'(trial_a), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        search(6, 1'b0, 1'b0);

        // non-one-hot (all-zero) flags for the whole search
        search(2, 1'b0, 1'b1);

        // start held high: one idle cycle between back-to-back searches
        @(negedge clk);
        b_val = 4'd12;
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_first_done", 32'(done), 1);
        chk("held_first_result", 32'(result), 12);
        @(posedge clk); #1;
        chk("held_idle_gap", 32'(busy), 0);
        @(posedge clk); #1;
        chk("held_restart_busy", 32'(busy), 1);
        chk("held_restart_trial", 32'(trial_a), 8);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_second_done", 32'(done), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            search(int'($urandom_range(0, (1 << W) - 1)), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
